// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment scan display stage.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package sevseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [1:0] SLOT_TIME_ONES  = 2'd0;
    localparam logic [1:0] SLOT_TIME_TENS  = 2'd1;
    localparam logic [1:0] SLOT_SCORE_ONES = 2'd2;
    localparam logic [1:0] SLOT_SCORE_TENS = 2'd3;

    typedef enum logic {
        BlinkVisible = 1'b0,
        BlinkOff     = 1'b1
    } blink_phase_e;

    // One coherent frame sample of everything the display shows.
    typedef struct packed {
        logic [3:0] time_ones;
        logic [3:0] time_tens;
        logic [3:0] score_ones;
        logic [3:0] score_tens;
        logic       timeout;
    } shadow_t;

    function automatic logic is_tens_slot(input logic [1:0] idx);
        return (idx == SLOT_TIME_TENS) || (idx == SLOT_SCORE_TENS);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
// Non-BCD codes 10..15 render as a dash.
module bcd_to_seg7
    import sevseg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (bcd < 4'd10) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/sevseg_scan.sv
// Four-digit multiplexed seven-segment display: time (slots 0-1) and score (slots 2-3).
// Define SEVSEG_BLINK_EN to blank the whole display periodically while timeout is set.
module sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_HALF  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] time_ones,
    input  logic [3:0] time_tens,
    input  logic [3:0] score_ones,
    input  logic [3:0] score_tens,
    input  logic       timeout,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            active_q, active_d;
    shadow_t         shd_q, shd_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            strobe;
    logic            snap;
    logic [3:0]      digit;
    logic            blank;
    logic [6:0]      seg_dec;
    logic            hide;

    assign strobe = (cnt_q == CntLast);

    // Scan sequencing. The display stays dark until the first strobe; that strobe
    // starts frame 0 and takes the first snapshot so slot 0 shows live data.
    always_comb begin
        cnt_d    = strobe ? '0 : cnt_q + CntW'(1);
        idx_d    = idx_q;
        active_d = active_q;
        snap     = 1'b0;
        if (strobe) begin
            if (!active_q) begin
                active_d = 1'b1;
                idx_d    = SLOT_TIME_ONES;
                snap     = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
                snap  = (idx_q == SLOT_SCORE_TENS);
            end
        end
    end

    always_comb begin
        shd_d = shd_q;
        if (snap) begin
            shd_d = '{
                time_ones:  time_ones,
                time_tens:  time_tens,
                score_ones: score_ones,
                score_tens: score_tens,
                timeout:    timeout
            };
        end
    end

    // Outputs are registered from next-state values so the new slot appears
    // exactly one cycle after its strobe.
    always_comb begin
        digit = shd_d.time_ones;
        unique case (idx_d)
            SLOT_TIME_ONES:  digit = shd_d.time_ones;
            SLOT_TIME_TENS:  digit = shd_d.time_tens;
            SLOT_SCORE_ONES: digit = shd_d.score_ones;
            SLOT_SCORE_TENS: digit = shd_d.score_tens;
            default:         digit = shd_d.time_ones;
        endcase
        blank = is_tens_slot(idx_d) && (digit == 4'd0);
    end

    bcd_to_seg7 u_dec (
        .bcd   (digit),
        .blank (blank),
        .seg   (seg_dec)
    );

`ifdef SEVSEG_BLINK_EN
    localparam int unsigned BlkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_HALF - 1);

    logic [BlkW-1:0] blink_cnt_q, blink_cnt_d;
    blink_phase_e    phase_q, phase_d;

    // Counting restarts on every entry into timeout; leaving it forces visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!shd_d.timeout) begin
            blink_cnt_d = '0;
            phase_d     = BlinkVisible;
        end else if (strobe) begin
            if (!shd_q.timeout) begin
                blink_cnt_d = '0;
                phase_d     = BlinkVisible;
            end else if (blink_cnt_q == BlkLast) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == BlinkOff) ? BlinkVisible : BlinkOff;
            end else begin
                blink_cnt_d = blink_cnt_q + BlkW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= BlinkVisible;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign hide = (phase_d == BlinkOff);
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_HALF == 0);
    assign hide = 1'b0;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (active_d) begin
            seg_d = seg_dec;
            dp_d  = (idx_d != SLOT_SCORE_ONES);
            if (!hide) begin
                an_d = ~(NUM_DIGITS'(1) << idx_d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= SLOT_TIME_ONES;
            active_q <= 1'b0;
            shd_q    <= '0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            shd_q    <= shd_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_sevseg_scan.sv
// Directed self-checking bench for sevseg_scan with REFRESH_DIV=4, BLINK_HALF=2.
module tb_sevseg_scan;

    localparam logic [6:0] P0    = 7'b1000000;
    localparam logic [6:0] P1    = 7'b1111001;
    localparam logic [6:0] P2    = 7'b0100100;
    localparam logic [6:0] P3    = 7'b0110000;
    localparam logic [6:0] P4    = 7'b0011001;
    localparam logic [6:0] P5    = 7'b0010010;
    localparam logic [6:0] P7    = 7'b1111000;
    localparam logic [6:0] P9    = 7'b0010000;
    localparam logic [6:0] PDASH = 7'b0111111;
    localparam logic [6:0] PBLK  = 7'h7F;

`ifdef SEVSEG_BLINK_EN
    localparam bit BlinkOn = 1'b1;
`else
    localparam bit BlinkOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] time_ones, time_tens, score_ones, score_tens;
    logic       timeout;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sevseg_scan #(
        .REFRESH_DIV (4),
        .BLINK_HALF  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .time_ones  (time_ones),
        .time_tens  (time_tens),
        .score_ones (score_ones),
        .score_tens (score_tens),
        .timeout    (timeout),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp);
        check_eq({tag, ".an"}, 32'(an), 32'(e_an));
        check_eq({tag, ".seg"}, 32'(seg), 32'(e_seg));
        check_eq({tag, ".dp"}, 32'(dp), 32'(e_dp));
    endtask

    task automatic slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                        input logic e_dp);
        step(4);
        check_out(tag, e_an, e_seg, e_dp);
    endtask

    initial begin
        rst        = 1'b1;
        time_ones  = 4'd5;
        time_tens  = 4'd2;
        score_ones = 4'd7;
        score_tens = 4'd1;
        timeout    = 1'b0;
        #1;
        check_out("reset", 4'b1111, PBLK, 1'b1);
        step(2);
        rst = 1'b0;

        // Dark until the first strobe, then slot 0 one cycle later.
        step(3);
        check_out("pre_first", 4'b1111, PBLK, 1'b1);
        step(1);
        check_out("f1_s0", 4'b1110, P5, 1'b1);
        step(3);
        check_eq("f1_s0_hold.an", 32'(an), 32'(4'b1110));
        step(1);
        check_out("f1_s1", 4'b1101, P2, 1'b1);
        slot("f1_s2", 4'b1011, P7, 1'b0);
        slot("f1_s3", 4'b0111, P1, 1'b1);

        // Zero tens digits blank; ones zeros do not.
        time_ones  = 4'd0;
        time_tens  = 4'd0;
        score_ones = 4'd0;
        score_tens = 4'd0;
        slot("lz_s0", 4'b1110, P0, 1'b1);
        slot("lz_s1", 4'b1101, PBLK, 1'b1);
        slot("lz_s2", 4'b1011, P0, 1'b0);
        slot("lz_s3", 4'b0111, PBLK, 1'b1);

        // Input change mid-frame must wait for the next snapshot.
        time_ones = 4'd3;
        time_tens = 4'd4;
        slot("tear_s0", 4'b1110, P3, 1'b1);
        slot("tear_s1", 4'b1101, P4, 1'b1);
        time_ones = 4'd9;
        time_tens = 4'd0;
        slot("tear_s2", 4'b1011, P0, 1'b0);
        slot("tear_s3", 4'b0111, PBLK, 1'b1);
        slot("tear_next_s0", 4'b1110, P9, 1'b1);
        slot("tear_next_s1", 4'b1101, PBLK, 1'b1);

        // Non-BCD shows a dash.
        time_ones = 4'hC;
        time_tens = 4'd4;
        slot("dash_prev_s2", 4'b1011, P0, 1'b0);
        slot("dash_prev_s3", 4'b0111, PBLK, 1'b1);
        slot("dash_s0", 4'b1110, PDASH, 1'b1);

        // Timeout raised: seen at the next snapshot.
        timeout = 1'b1;
        slot("to_pre_s1", 4'b1101, P4, 1'b1);
        slot("to_pre_s2", 4'b1011, P0, 1'b0);
        slot("to_pre_s3", 4'b0111, PBLK, 1'b1);
        slot("bl1_s0", 4'b1110, PDASH, 1'b1);
        slot("bl1_s1", 4'b1101, P4, 1'b1);
        step(4);
        check_eq("bl1_s2.an", 32'(an), 32'(BlinkOn ? 4'b1111 : 4'b1011));
        step(4);
        check_eq("bl1_s3.an", 32'(an), 32'(BlinkOn ? 4'b1111 : 4'b0111));
        slot("bl2_s0", 4'b1110, PDASH, 1'b1);
        timeout = 1'b0;
        slot("bl2_s1", 4'b1101, P4, 1'b1);
        step(4);
        check_eq("bl2_s2.an", 32'(an), 32'(BlinkOn ? 4'b1111 : 4'b1011));
        step(4);
        check_eq("bl2_s3.an", 32'(an), 32'(BlinkOn ? 4'b1111 : 4'b0111));
        slot("steady_s0", 4'b1110, PDASH, 1'b1);
        slot("steady_s1", 4'b1101, P4, 1'b1);
        slot("steady_s2", 4'b1011, P0, 1'b0);

        // Reset mid-slot 2 blanks without waiting for a clock edge.
        step(2);
        rst = 1'b1;
        #1;
        check_out("rst_mid", 4'b1111, PBLK, 1'b1);
        step(1);
        rst = 1'b0;
        step(3);
        check_out("rst_dark", 4'b1111, PBLK, 1'b1);
        step(1);
        check_out("rst_s0", 4'b1110, PDASH, 1'b1);
        slot("rst_s1", 4'b1101, P4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
